instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4: encoded-word FIFO depth, power of two, 2..16.
REQ-002 Parameter AW, default 10: instruction-memory address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse; begins a program load (ignored unless IDLE).
REQ-006 base_addr  input  AW  first write address, sampled on accepted start.
REQ-007 in_valid / in_ready  input / output  1 / 1  instruction-entry handshake; transfer when both high.
REQ-008 in_id  input  6  decoder instruction ID to encode.
REQ-009 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-010 in_imm  input  16  I-type immediate; in_jaddr  input  26  J-type target.
REQ-011 in_last  input  1  marks final entry of the program.
REQ-012 mem_we  output  1  write request; mem_addr  output  AW; mem_wdata  output  32.
REQ-013 mem_ack  input  1  memory accepts current write this cycle.
REQ-014 busy  output  1  high outside IDLE; done  output  1  one-cycle pulse on load completion.
REQ-015 count  output  AW+1  words written in current/last load; err  output  1  illegal-ID flag.

Function
REQ-016 Encoding: IDs 0-7 R-type: {6'b000001, rs, rt, rd, shamt, 3'b000, id[2:0]}.
REQ-017 IDs 8-15 I-type: {3'b001, id[2:0], rs, rt, imm}; IDs 16-23 J-type: {3'b010, id[2:0], jaddr}.
REQ-018 IDs 24-63 are illegal: accepted but never written to memory and not counted.
REQ-019 Encoding is combinational on the input fields; an encoded word enters the FIFO in the cycle its input is transferred.
REQ-020 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on transfer with in_last=1; DRAIN->IDLE when FIFO empty and no write pending.
REQ-021 in_ready = (state==RUN) && FIFO not full; in_ready low in IDLE and DRAIN.
REQ-022 The FIFO head drives mem_wdata with mem_we high while the FIFO is non-empty; mem_addr/mem_wdata stay stable until mem_ack.
REQ-023 On mem_ack with mem_we high: pop FIFO, increment mem_addr and count; mem_addr wraps from 2^AW-1 to 0.
REQ-024 Simultaneous push and pop on a full FIFO is permitted only when in_ready was high (not full); on a full FIFO, pop frees a slot visible the next cycle.
REQ-025 Minimum latency: accepted entry -> mem_we asserted next cycle when FIFO was empty.
REQ-026 done pulses exactly one cycle, in the cycle state returns to IDLE; count holds its value until next start.
REQ-027 An in_last entry with an illegal ID still ends the load.
REQ-028 start while busy is ignored; mem_ack while mem_we low is ignored.

Reset
REQ-029 rst forces state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0, done=0, busy=0, in_ready=0.
REQ-030 rst mid-load abandons pending FIFO words; no further writes issue.

Configuration
REQ-031 Macro INSTR_ENC_ILLEGAL_TRAP_EN defined: illegal ID sets err sticky until next accepted start or rst.
REQ-032 Macro undefined: illegal IDs are dropped silently and err is tied 0.

Verification
REQ-033 start, base=0x010; id=0 rs=15 rt=15 rd=31 shamt=31 last -> one write addr 0x010 data 0x05EFFFC0, done, count=1.
REQ-034 id=9 rs=6 rt=15 imm=0, then id=21 jaddr=0x10F0000 last -> data 0x24CF0000 @base, 0x550F0000 @base+1.
REQ-035 mem_ack held low 10 cycles, 5 entries sent -> in_ready low after 4, mem_addr/data stable, all 5 written in order.
REQ-036 base=0x3FF, 2 entries -> writes at 0x3FF then 0x000.
REQ-037 id=30 then id=0 last with macro defined -> err=1, count=1; macro undefined -> err=0, count=1.
REQ-038 rst asserted with 3 words queued -> mem_we=0 next cycle, busy=0, count=0, no done pulse.

Source files
------------

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Encodes decoder instruction IDs into 32-bit words and streams
//               them through a small FIFO into instruction memory.
//               Optional macro INSTR_ENC_ILLEGAL_TRAP_EN makes illegal IDs
//               raise a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_id,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_jaddr,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_FILL_FULL = (c_PTR_W+1)'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [31:0]        r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_fill;
    logic [AW-1:0]      r_addr;
    logic [AW:0]        r_count;
    logic               r_done;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_full;
    logic        w_empty;
    logic        w_ready;
    logic        w_xfer;
    logic        w_push;
    logic        w_pop;
    logic        w_start_ok;

    // Upper three ID bits select the instruction format; everything above J is illegal.
    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b1;
        case (in_id[5:3])
            3'd0:    w_word = {6'b000001, in_rs, in_rt, in_rd, in_shamt, 3'b000, in_id[2:0]};
            3'd1:    w_word = {3'b001, in_id[2:0], in_rs, in_rt, in_imm};
            3'd2:    w_word = {3'b010, in_id[2:0], in_jaddr};
            default: w_legal = 1'b0;
        endcase
    end

    assign w_full     = (r_fill == c_FILL_FULL);
    assign w_empty    = (r_fill == '0);
    assign w_ready    = (r_state == c_RUN) && !w_full;
    assign w_xfer     = in_valid && w_ready;
    assign w_push     = w_xfer && w_legal;
    assign w_pop      = !w_empty && mem_ack;
    assign w_start_ok = start && (r_state == c_IDLE);

    assign in_ready  = w_ready;
    assign mem_we    = !w_empty;
    assign mem_wdata = w_empty ? 32'd0 : r_fifo[r_rd_ptr];
    assign mem_addr  = r_addr;
    assign count     = r_count;
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE:  if (start) r_state <= c_RUN;
                c_RUN:   if (w_xfer && in_last) r_state <= c_DRAIN;
                c_DRAIN: begin
                    if (w_empty) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Storage carries no reset; r_fill alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (w_start_ok) begin
            r_addr  <= base_addr;
            r_count <= '0;
        end else if (w_pop) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count + 1'b1;
        end
    end

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_xfer && !w_legal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    localparam logic c_EXP_ERR = 1'b1;
`else
    localparam logic c_EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_id;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [15:0]   in_imm;
    logic [25:0]   in_jaddr;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] wr_addr [0:63];
    logic [31:0]   wr_data [0:63];
    int            wr_n     = 0;
    int            done_cnt = 0;

    instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_jaddr(in_jaddr), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .busy(busy), .done(done), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    // Log every accepted memory write and every done pulse.
    always @(posedge clk) begin
        if (!rst && mem_we && mem_ack) begin
            wr_addr[wr_n % 64] <= mem_addr;
            wr_data[wr_n % 64] <= mem_wdata;
            wr_n <= wr_n + 1;
        end
        if (!rst && done) done_cnt <= done_cnt + 1;
    end

    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [5:0] id, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] ja, input logic last);
        int n;
        in_id = id; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_jaddr = ja; in_last = last; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout in_ready=%0b expected=1 id=%0d", in_ready, id);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done got=%0b expected=1", name, done);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_at_done got=%0b expected=0", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_width got=%0b expected=0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_id = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
        in_jaddr = '0; in_last = 1'b0; mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_we !== 1'b0)     begin failures++; $display("FAIL reset_mem_we got=%0b expected=0", mem_we); end
        checks++; if (mem_addr !== '0)     begin failures++; $display("FAIL reset_mem_addr got=%0h expected=0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%0h expected=0", mem_wdata); end
        checks++; if (count !== '0)        begin failures++; $display("FAIL reset_count got=%0d expected=0", count); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0b expected=0", busy); end
        checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL reset_in_ready got=%0b expected=0", in_ready); end
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%0b expected=0", done); end
        checks++; if (err !== 1'b0)        begin failures++; $display("FAIL reset_err got=%0b expected=0", err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        int n0, d0;
        n0 = wr_n; d0 = done_cnt;
        do_start(10'h010);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rtype_busy got=%0b expected=1", busy); end
        send(6'd0, 5'd15, 5'd15, 5'd31, 5'd31, 16'h0, 26'h0, 1'b1);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rtype_latency mem_we=%0b expected=1", mem_we); end
        wait_done("rtype");
        checks++; if (wr_n - n0 !== 1)         begin failures++; $display("FAIL rtype_nwrites got=%0d expected=1", wr_n - n0); end
        checks++; if (wr_addr[n0] !== 10'h010) begin failures++; $display("FAIL rtype_addr got=%0h expected=010", wr_addr[n0]); end
        checks++; if (wr_data[n0] !== 32'h05EFFFC0) begin failures++; $display("FAIL rtype_data got=%08h expected=05EFFFC0", wr_data[n0]); end
        checks++; if (count !== 11'd1)         begin failures++; $display("FAIL rtype_count got=%0d expected=1", count); end
        checks++; if (done_cnt - d0 !== 1)     begin failures++; $display("FAIL rtype_done_pulses got=%0d expected=1", done_cnt - d0); end
    endtask

    task automatic test_itype_jtype();
        int n0;
        n0 = wr_n;
        do_start(10'h100);
        send(6'd9, 5'd6, 5'd15, 5'd0, 5'd0, 16'h0000, 26'h0, 1'b0);
        send(6'd21, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10F0000, 1'b1);
        wait_done("ij");
        checks++; if (wr_n - n0 !== 2)              begin failures++; $display("FAIL ij_nwrites got=%0d expected=2", wr_n - n0); end
        checks++; if (wr_addr[n0] !== 10'h100)      begin failures++; $display("FAIL ij_addr0 got=%0h expected=100", wr_addr[n0]); end
        checks++; if (wr_data[n0] !== 32'h24CF0000) begin failures++; $display("FAIL ij_data0 got=%08h expected=24CF0000", wr_data[n0]); end
        checks++; if (wr_addr[n0+1] !== 10'h101)    begin failures++; $display("FAIL ij_addr1 got=%0h expected=101", wr_addr[n0+1]); end
        checks++; if (wr_data[n0+1] !== 32'h550F0000) begin failures++; $display("FAIL ij_data1 got=%08h expected=550F0000", wr_data[n0+1]); end
        checks++; if (count !== 11'd2)              begin failures++; $display("FAIL ij_count got=%0d expected=2", count); end
    endtask

    task automatic test_backpressure();
        int   n0;
        logic bad;
        n0 = wr_n;
        mem_ack = 1'b0;
        do_start(10'h020);
        for (int k = 1; k <= 4; k++)
            send(6'(k), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        in_id = 6'd5; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_last = 1'b1; in_valid = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 10'h020 ||
                mem_wdata !== 32'h04000001)
                bad = 1'b1;
            start     = (c == 0);
            base_addr = 10'h3AA;
        end
        start = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_stall in_ready=%0b mem_we=%0b addr=%0h data=%08h expected 0/1/020/04000001",
                     in_ready, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        send(6'd5, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        wait_done("bp");
        checks++; if (wr_n - n0 !== 5) begin failures++; $display("FAIL bp_nwrites got=%0d expected=5", wr_n - n0); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_addr[n0+i] !== 10'(32'h020 + i) || wr_data[n0+i] !== 32'h04000001 + 32'(i)) begin
                failures++;
                $display("FAIL bp_write%0d addr=%0h data=%08h expected addr=%0h data=%08h",
                         i, wr_addr[n0+i], wr_data[n0+i], 32'h020 + i, 32'h04000001 + i);
            end
        end
        checks++; if (count !== 11'd5) begin failures++; $display("FAIL bp_count got=%0d expected=5", count); end
    endtask

    task automatic test_wrap();
        int n0;
        n0 = wr_n;
        do_start(10'h3FF);
        send(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        send(6'd8, 5'd0, 5'd0, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
        wait_done("wrap");
        checks++; if (wr_addr[n0] !== 10'h3FF)   begin failures++; $display("FAIL wrap_addr0 got=%0h expected=3FF", wr_addr[n0]); end
        checks++; if (wr_addr[n0+1] !== 10'h000) begin failures++; $display("FAIL wrap_addr1 got=%0h expected=000", wr_addr[n0+1]); end
        checks++; if (wr_data[n0+1] !== 32'h20001234) begin failures++; $display("FAIL wrap_data1 got=%08h expected=20001234", wr_data[n0+1]); end
        checks++; if (count !== 11'd2) begin failures++; $display("FAIL wrap_count got=%0d expected=2", count); end
    endtask

    task automatic test_illegal();
        int n0;
        n0 = wr_n;
        do_start(10'h040);
        send(6'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        checks++; if (err !== c_EXP_ERR) begin failures++; $display("FAIL illegal_err got=%0b expected=%0b", err, c_EXP_ERR); end
        send(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        wait_done("illegal");
        checks++; if (count !== 11'd1)   begin failures++; $display("FAIL illegal_count got=%0d expected=1", count); end
        checks++; if (wr_n - n0 !== 1)   begin failures++; $display("FAIL illegal_nwrites got=%0d expected=1", wr_n - n0); end
        checks++; if (wr_data[n0] !== 32'h04000000) begin failures++; $display("FAIL illegal_data got=%08h expected=04000000", wr_data[n0]); end
        checks++; if (err !== c_EXP_ERR) begin failures++; $display("FAIL illegal_err_sticky got=%0b expected=%0b", err, c_EXP_ERR); end
        // An illegal entry flagged last must still terminate the load.
        n0 = wr_n;
        do_start(10'h060);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL illegal_err_clear got=%0b expected=0", err); end
        send(6'd40, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b1);
        wait_done("illegal_last");
        checks++; if (count !== 11'd0) begin failures++; $display("FAIL illegal_last_count got=%0d expected=0", count); end
        checks++; if (wr_n - n0 !== 0) begin failures++; $display("FAIL illegal_last_nwrites got=%0d expected=0", wr_n - n0); end
        checks++; if (err !== c_EXP_ERR) begin failures++; $display("FAIL illegal_last_err got=%0b expected=%0b", err, c_EXP_ERR); end
    endtask

    task automatic test_reset_midload();
        int n0, d0;
        mem_ack = 1'b0;
        do_start(10'h050);
        for (int k = 0; k < 3; k++)
            send(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL midrst_pending mem_we=%0b expected=1", mem_we); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b0)   begin failures++; $display("FAIL midrst_mem_we got=%0b expected=0", mem_we); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL midrst_busy got=%0b expected=0", busy); end
        checks++; if (count !== '0)      begin failures++; $display("FAIL midrst_count got=%0d expected=0", count); end
        checks++; if (mem_addr !== '0)   begin failures++; $display("FAIL midrst_addr got=%0h expected=0", mem_addr); end
        checks++; if (err !== 1'b0)      begin failures++; $display("FAIL midrst_err got=%0b expected=0", err); end
        rst = 1'b0;
        mem_ack = 1'b1;
        n0 = wr_n; d0 = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (wr_n - n0 !== 0)     begin failures++; $display("FAIL midrst_writes got=%0d expected=0", wr_n - n0); end
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL midrst_done got=%0d expected=0", done_cnt - d0); end
        checks++; if (mem_we !== 1'b0)     begin failures++; $display("FAIL midrst_mem_we_after got=%0b expected=0", mem_we); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype_jtype();
        test_backpressure();
        test_wrap();
        test_illegal();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
